// File: rtl/mpc_tx_scheduler.sv
// Two-requester scheduler for the MPC DDR output mux: LCT pairs preempt injections, which resume afterwards.
// Registered outputs, one-edge latency (inj_rd is combinational); requesters hold their req until acked.
module mpc_tx_scheduler #(
  parameter int WIDTH        = 8,
  parameter int BLANK_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tx_en,
  input  logic               lct_req,
  input  logic [2*WIDTH-1:0] lct_frame0,
  input  logic [2*WIDTH-1:0] lct_frame1,
  output logic               lct_ack,
  input  logic               inj_req,
  input  logic [7:0]         inj_len,
  input  logic [2*WIDTH-1:0] inj_data,
  output logic               inj_rd,
  output logic               inj_ack,
  output logic               inj_abort,
  output logic [WIDTH-1:0]   mux_din1st,
  output logic [WIDTH-1:0]   mux_din2nd,
  output logic               mux_ce,
  output logic               mux_set,
  output logic [15:0]        lct_count
);

  localparam int              W2   = 2 * WIDTH;
  localparam logic [W2-1:0]   ONES = '1;

  typedef enum logic [1:0] {S_BLANK, S_IDLE, S_LCT1, S_INJ} state_t;

  state_t          state;
  logic [7:0]      blank_cnt;
  logic [7:0]      rem;
  logic [W2-1:0]   frame1_q;
  logic            suspended;
  logic            gap;

  // Must mirror exactly the branches below that load inj_data.
  always_comb begin
    inj_rd = 1'b0;
    case (state)
      S_IDLE:  inj_rd = tx_en && !gap && !lct_req &&
                        (suspended || (inj_req && inj_len != 8'd0));
      S_INJ:   inj_rd = tx_en && !lct_req && (rem != 8'd0);
      default: inj_rd = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                    <= S_BLANK;
      blank_cnt                <= 8'(BLANK_CYCLES);
      rem                      <= 8'd0;
      frame1_q                 <= '0;
      suspended                <= 1'b0;
      gap                      <= 1'b0;
      mux_set                  <= 1'b1;
      mux_ce                   <= 1'b0;
      {mux_din1st, mux_din2nd} <= ONES;
      lct_ack                  <= 1'b0;
      inj_ack                  <= 1'b0;
      inj_abort                <= 1'b0;
      lct_count                <= 16'd0;
    end else begin
      lct_ack   <= 1'b0;
      inj_ack   <= 1'b0;
      inj_abort <= 1'b0;
      case (state)
        S_BLANK: begin
          if (blank_cnt == 8'd1) begin
            blank_cnt <= 8'd0;
            state     <= S_IDLE;
            mux_set   <= 1'b0;
            mux_ce    <= 1'b1;
          end else begin
            blank_cnt <= blank_cnt - 8'd1;
          end
        end
        S_IDLE: begin
          {mux_din1st, mux_din2nd} <= ONES;
          // The edge right after an LCT pair always idles, so a pair is never butted against other traffic.
          if (gap) begin
            gap <= 1'b0;
          end else if (!tx_en) begin
            if (suspended) begin
              suspended <= 1'b0;
              rem       <= 8'd0;
              inj_ack   <= 1'b1;
              inj_abort <= 1'b1;
            end
          end else if (lct_req) begin
            {mux_din1st, mux_din2nd} <= lct_frame0;
            frame1_q <= lct_frame1;
            lct_ack  <= 1'b1;
            state    <= S_LCT1;
            if (lct_count != 16'hffff) lct_count <= lct_count + 16'd1;
          end else if (suspended) begin
            {mux_din1st, mux_din2nd} <= inj_data;
            suspended <= 1'b0;
            rem       <= rem - 8'd1;
            state     <= S_INJ;
          end else if (inj_req) begin
            if (inj_len == 8'd0) begin
              inj_ack <= 1'b1;
            end else begin
              {mux_din1st, mux_din2nd} <= inj_data;
              rem   <= inj_len - 8'd1;
              state <= S_INJ;
            end
          end
        end
        S_LCT1: begin
          {mux_din1st, mux_din2nd} <= frame1_q;
          gap   <= 1'b1;
          state <= S_IDLE;
        end
        S_INJ: begin
          if (rem == 8'd0) begin
            {mux_din1st, mux_din2nd} <= ONES;
            inj_ack <= 1'b1;
            state   <= S_IDLE;
          end else if (lct_req && tx_en) begin
            {mux_din1st, mux_din2nd} <= lct_frame0;
            frame1_q  <= lct_frame1;
            lct_ack   <= 1'b1;
            suspended <= 1'b1;
            state     <= S_LCT1;
            if (lct_count != 16'hffff) lct_count <= lct_count + 16'd1;
          end else if (!tx_en) begin
            {mux_din1st, mux_din2nd} <= ONES;
            rem       <= 8'd0;
            inj_ack   <= 1'b1;
            inj_abort <= 1'b1;
            state     <= S_IDLE;
          end else begin
            {mux_din1st, mux_din2nd} <= inj_data;
            rem <= rem - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
